// File: rtl/onehot_grant_decoder_if.sv
// Handshake and grant bus between an index master, the grant decoder and the per-line targets.
interface onehot_grant_decoder_if #(
  parameter int IDX_W = 4
);
  localparam int N = 2 ** IDX_W;

  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] data_in;
  logic [N-1:0]     ack_in;
  logic [N-1:0]     data_out;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             err_spurious;

  modport master (
    output idx_valid, data_in, ack_in,
    input  idx_ready, data_out, busy, done, timeout, err_spurious
  );

  modport slave (
    input  idx_valid, data_in, ack_in,
    output idx_ready, data_out, busy, done, timeout, err_spurious
  );
endinterface

// File: rtl/onehot_grant_decoder.sv
// Index-to-one-hot grant issuer: grants one line, waits for its ack to rise and fall,
// and aborts with a timeout pulse if the target stalls in either phase.
//
// state   | meaning
// IDLE    | no grant, ready to accept an index
// GRANT   | one-hot grant driven, waiting for ack on the granted line
// RELEASE | grant removed, waiting for the granted line's ack to drop
module onehot_grant_decoder #(
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input logic                  clk,
  input logic                  rst,
  onehot_grant_decoder_if.slave bus
);
  localparam int N = 2 ** IDX_W;
  localparam logic [N-1:0]    ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TO_W-1:0]  cnt;
  logic [N-1:0]     grant_q;
  logic             done_q;
  logic             timeout_q;
  logic             err_q;
  logic [N-1:0]     line_mask;
  logic             ack_sel;

  assign line_mask = ONE << idx;
  assign ack_sel   = bus.ack_in[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      // Acks from any other line while busy are flagged but never acted on.
      err_q     <= (state != IDLE) && |(bus.ack_in & ~line_mask);
      case (state)
        IDLE: begin
          grant_q <= '0;
          if (bus.idx_valid) begin
            idx     <= bus.data_in;
            grant_q <= ONE << bus.data_in;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (ack_sel) begin
            grant_q <= '0;
            cnt     <= '0;
            state   <= RELEASE;
          end else if (cnt == CNT_LAST) begin
            grant_q   <= '0;
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        RELEASE: begin
          grant_q <= '0;
          if (!ack_sel) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: begin
          grant_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.idx_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.data_out     = grant_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Randomized scoreboard bench for onehot_grant_decoder: a driver pushes the outcome predicted
// from ack timing, a monitor pops and compares on every done/timeout pulse.
module tb_onehot_grant_decoder;
  localparam int IDX_W   = 4;
  localparam int N       = 16;
  localparam int TIMEOUT = 15;

  typedef struct {
    int idx;
    bit is_done;
    int grant_len;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  onehot_grant_decoder_if #(.IDX_W(IDX_W)) bus ();

  onehot_grant_decoder #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome from the rules: ack seen at grant edge d+1 ends the grant (ack beats the timeout
  // on the last edge); ack held for h edges lets release finish only if it drops in time.
  function automatic exp_t predict(input int idx, input int d, input int h, input bit sp);
    exp_t e;
    e.idx = idx;
    e.err = sp;
    if (d < 0 || d >= TIMEOUT) begin
      e.grant_len = TIMEOUT;
      e.is_done   = 1'b0;
    end else begin
      e.grant_len = d + 1;
      e.is_done   = (h <= TIMEOUT);
    end
    return e;
  endfunction

  int glen = 0;
  int errs = 0;
  bit gbad = 1'b0;
  logic [N-1:0] one16 = 16'h0001;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.data_out != '0) begin
        glen++;
        if (sb.size() == 0) gbad = 1'b1;
        else if (bus.data_out !== (one16 << sb[0].idx)) gbad = 1'b1;
      end
      if (bus.err_spurious) errs++;
      if (bus.done || bus.timeout) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: done=%0b timeout=%0b with empty scoreboard", bus.done, bus.timeout);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done", 32'(bus.done), 32'(e.is_done));
          chk("timeout", 32'(bus.timeout), 32'(!e.is_done));
          chk("grant_len", 32'(glen), 32'(e.grant_len));
          chk("grant_onehot", 32'(gbad), 32'd0);
          chk("err_spurious", 32'(errs != 0), 32'(e.err));
        end
        glen = 0;
        errs = 0;
        gbad = 1'b0;
      end
    end
  end

  task automatic run_txn(input int idx, input int d, input int h, input bit sp, input int sp_line);
    int n = 0;
    @(negedge clk);
    while (!bus.idx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.idx_ready) begin
      total++;
      bad++;
      $display("FAIL idx_ready_wait: got 0 expected 1 after %0d cycles", n);
      return;
    end
    bus.ack_in = '0;
    sb.push_back(predict(idx, d, h, sp));
    bus.idx_valid = 1'b1;
    bus.data_in   = 4'(idx);
    if (d == 0) bus.ack_in[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.idx_valid = 1'b0;
    if (sp) bus.ack_in[sp_line] = 1'b1;
    if (d >= 0) begin
      if (d >= 1) repeat (d) @(negedge clk);
      bus.ack_in[idx] = 1'b1;
      repeat (h) @(negedge clk);
      bus.ack_in[idx] = 1'b0;
    end
  endtask

  initial begin
    bus.idx_valid = 1'b0;
    bus.data_in   = '0;
    bus.ack_in    = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_idx_ready", 32'(bus.idx_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pulses", {29'd0, bus.done, bus.timeout, bus.err_spurious}, 32'd0);

    mon_en = 1'b1;
    run_txn(5, 2, 2, 1'b0, 0);
    run_txn(15, -1, 0, 1'b0, 0);
    run_txn(0, 0, 3, 1'b0, 0);
    run_txn(3, 4, 1, 1'b1, 7);
    run_txn(0, 14, 1, 1'b0, 0);
    run_txn(15, 3, 15, 1'b0, 0);
    run_txn(8, 1, 16, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      int idx, d, h, spl;
      bit sp;
      idx = int'($urandom_range(0, N - 1));
      d   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 17));
      h   = int'($urandom_range(1, 17));
      sp  = ($urandom_range(0, 3) == 0);
      spl = (idx + 1 + int'($urandom_range(0, N - 2))) % N;
      run_txn(idx, d, h, sp, spl);
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    end
    mon_en = 1'b0;
    bus.ack_in = '0;

    // Reset in the middle of a grant on line 9.
    @(negedge clk);
    bus.idx_valid = 1'b1;
    bus.data_in   = 4'd9;
    @(posedge clk);
    @(negedge clk);
    bus.idx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_grant_data_out", 32'(bus.data_out), 32'(one16 << 9));
    chk("mid_grant_busy", {30'd0, bus.busy, bus.idx_ready}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_mid_ready_busy", {30'd0, bus.idx_ready, bus.busy}, 32'd2);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.done || bus.timeout || bus.data_out != '0) seen = 1'b1;
        @(negedge clk);
      end
      chk("rst_mid_no_pulse", 32'(seen), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
